// File: rtl/eth_axis_rx_frame_buffer.sv
// Receive-side frame sink: writes good AXI-Stream frames into a word ring buffer,
// queues their byte lengths and drops bad, malformed or non-fitting frames whole.
module eth_axis_rx_frame_buffer #(
    parameter int ADDR_WIDTH      = 10,
    parameter int LEN_FIFO_LOG2   = 3,
    parameter int MAX_FRAME_BYTES = 1536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        frame_valid,
    output logic [15:0] frame_len,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    input  logic        frame_pop,
    output logic [15:0] good_count,
    output logic [15:0] drop_count
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int QW = LEN_FIFO_LOG2 + 1;
    localparam logic [PW-1:0] RAM_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [QW-1:0] LEN_SLOTS = {1'b1, {LEN_FIFO_LOG2{1'b0}}};
    localparam logic [QW-1:0] Q_ONE     = {{LEN_FIFO_LOG2{1'b0}}, 1'b1};
    localparam logic [16:0]   MAX_BYTES = 17'(MAX_FRAME_BYTES);

    typedef enum logic [0:0] {RECV = 1'b0, DROP = 1'b1} state_t;

    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        keep_bytes = {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
    endfunction

    function automatic logic keep_legal(input logic [3:0] keep);
        case (keep)
            4'h1, 4'h3, 4'h7, 4'hF: keep_legal = 1'b1;
            default:                keep_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0] ram_r   [0:2**ADDR_WIDTH-1];
    logic [15:0] len_q_r [0:2**LEN_FIFO_LOG2-1];

    state_t      state_r;
    logic        tready_r;
    logic [PW-1:0] wr_ptr_r, wr_commit_r, rd_base_r, rd_ptr_r;
    logic [QW-1:0] lq_wr_r, lq_rd_r;
    logic [15:0] byte_cnt_r;
    logic        bad_r;
    logic [31:0] rd_data_r;
    logic [15:0] good_r, drop_r;

    logic          accept_s, full_s, lq_full_s, fv_s, beat_bad_s, pop_s, read_s;
    logic [PW-1:0] used_s, head_words_s;
    logic [16:0]   new_cnt_s;
    logic [15:0]   head_len_s;
    logic          ram_wr_s, commit_s, drop_s, enter_drop_s;

    assign accept_s     = s_axis_tvalid & tready_r;
    assign used_s       = wr_ptr_r - rd_base_r;
    assign full_s       = (used_s == RAM_WORDS);
    assign lq_full_s    = ((lq_wr_r - lq_rd_r) == LEN_SLOTS);
    assign fv_s         = (lq_wr_r != lq_rd_r);
    assign new_cnt_s    = {1'b0, byte_cnt_r} + {14'd0, keep_bytes(s_axis_tkeep)};
    assign beat_bad_s   = ~keep_legal(s_axis_tkeep) | (~s_axis_tlast & (s_axis_tkeep != 4'hF));
    assign head_len_s   = len_q_r[lq_rd_r[LEN_FIFO_LOG2-1:0]];
    assign head_words_s = PW'(({1'b0, head_len_s} + 17'd3) >> 2);
    assign pop_s        = frame_pop & fv_s;
    // A read stops once the head frame's words are exhausted; pop takes priority.
    assign read_s       = rd_en & fv_s & ~pop_s & ((rd_ptr_r - rd_base_r) != head_words_s);

    // Per-beat write-side decision: store, commit, drop, or switch to discarding.
    always_comb begin
        ram_wr_s     = 1'b0;
        commit_s     = 1'b0;
        drop_s       = 1'b0;
        enter_drop_s = 1'b0;
        if (accept_s && (state_r == RECV)) begin
            if (s_axis_tlast) begin
                if (!s_axis_tuser && !bad_r && !beat_bad_s && (new_cnt_s != 17'd0) &&
                    (new_cnt_s <= MAX_BYTES) && !lq_full_s && !full_s) begin
                    commit_s = 1'b1;
                    ram_wr_s = 1'b1;
                end else begin
                    drop_s = 1'b1;
                end
            end else if (full_s || (new_cnt_s > MAX_BYTES)) begin
                enter_drop_s = 1'b1;
            end else begin
                ram_wr_s = 1'b1;
            end
        end else if (accept_s && s_axis_tlast) begin
            drop_s = 1'b1;
        end else begin
            ram_wr_s = 1'b0;
        end
    end

    // Frame storage and length queue; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
        if (ram_wr_s && !rst) begin
            ram_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        end
        if (commit_s && !rst) begin
            len_q_r[lq_wr_r[LEN_FIFO_LOG2-1:0]] <= new_cnt_s[15:0];
        end
    end

    // Write FSM, pointers, counters and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RECV;
            tready_r    <= 1'b0;
            wr_ptr_r    <= '0;
            wr_commit_r <= '0;
            rd_base_r   <= '0;
            rd_ptr_r    <= '0;
            lq_wr_r     <= '0;
            lq_rd_r     <= '0;
            byte_cnt_r  <= 16'd0;
            bad_r       <= 1'b0;
            rd_data_r   <= 32'd0;
            good_r      <= 16'd0;
            drop_r      <= 16'd0;
        end else begin
            tready_r <= 1'b1;
            if (commit_s) begin
                wr_ptr_r    <= wr_ptr_r + PTR_ONE;
                wr_commit_r <= wr_ptr_r + PTR_ONE;
                lq_wr_r     <= lq_wr_r + Q_ONE;
                good_r      <= sat_inc(good_r);
                byte_cnt_r  <= 16'd0;
                bad_r       <= 1'b0;
                state_r     <= RECV;
            end else if (drop_s) begin
                wr_ptr_r   <= wr_commit_r;
                drop_r     <= sat_inc(drop_r);
                byte_cnt_r <= 16'd0;
                bad_r      <= 1'b0;
                state_r    <= RECV;
            end else if (enter_drop_s) begin
                state_r <= DROP;
            end else if (ram_wr_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                byte_cnt_r <= new_cnt_s[15:0];
                bad_r      <= bad_r | beat_bad_s;
            end
            if (pop_s) begin
                lq_rd_r   <= lq_rd_r + Q_ONE;
                rd_base_r <= rd_base_r + head_words_s;
                rd_ptr_r  <= rd_base_r + head_words_s;
            end else if (read_s) begin
                rd_data_r <= ram_r[rd_ptr_r[ADDR_WIDTH-1:0]];
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign frame_valid   = fv_s;
    assign frame_len     = fv_s ? head_len_s : 16'd0;
    assign rd_data       = rd_data_r;
    assign good_count    = good_r;
    assign drop_count    = drop_r;
endmodule

// File: doc/eth_axis_rx_frame_buffer.md
Name: eth_axis_rx_frame_buffer

Overview:
- Receive-side frame sink for the Ethernet datapath: consumes the 32-bit AXI-Stream output of the 1G MAC FIFO (rx_axis_*), the opposite end of the transmit stream the MAC is fed with.
- Stores only good, complete frames in a word-addressed ring buffer and queues each frame's byte length.
- Presents frames to the CPU/DMA side through a sequential read port. Bad, malformed or non-fitting frames are dropped whole and counted.

Parameters:
- ADDR_WIDTH, 10, log2 of ring buffer depth in 32-bit words (1024 words).
- LEN_FIFO_LOG2, 3, log2 of the length-queue depth (8 frames).
- MAX_FRAME_BYTES, 1536, frames longer than this are dropped.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  32  frame data, byte 0 in [7:0]
- s_axis_tkeep  in  4  byte enables, legal values 4'h1/4'h3/4'h7/4'hF
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- s_axis_tlast  in  1  last beat of frame
- s_axis_tuser  in  1  bad-frame flag, sampled on the tlast beat
- frame_valid  out  1  at least one committed frame queued
- frame_len  out  16  byte length of the head frame (first-word-fall-through)
- rd_en  in  1  read next word of the head frame
- rd_data  out  32  read word, registered, valid 1 cycle after rd_en
- frame_pop  in  1  release the head frame
- good_count  out  16  committed frames, saturating
- drop_count  out  16  dropped frames, saturating

Behaviour:
- Reset values:
  - s_axis_tready=0, frame_valid=0, frame_len=0, rd_data=0, both counters=0.
  - All pointers=0, length queue empty, write FSM=RECV with byte count 0.
- s_axis_tready:
  - Registered; goes 1 on the first cycle after rst deasserts and stays 1.
  - No backpressure is ever applied; overflow is handled by dropping.
- Pointers are ADDR_WIDTH+1 bits:
  - wr_ptr: tentative write position.
  - wr_commit: end of the last committed frame.
  - rd_base: start of the head frame.
  - rd_ptr: word read position.
- used = wr_ptr - rd_base. Buffer is full when used == 2^ADDR_WIDTH.
- FSM state RECV, per accepted beat:
  - Write tdata at wr_ptr[ADDR_WIDTH-1:0] and increment wr_ptr.
  - Add popcount(tkeep) to the 16-bit byte count.
  - Set the sticky bad flag if tkeep != 4'hF on a non-last beat, or if tkeep is illegal on any beat.
- FSM transitions to DROP, on a non-last beat only:
  - The buffer is full, so the beat is not written.
  - The byte count would exceed MAX_FRAME_BYTES.
- FSM state DROP:
  - Accept and discard beats until tlast, then perform the drop action and return to RECV.
- On the tlast beat in RECV, the frame is committed if all of these hold: tuser=0, bad=0, total length between 1 and MAX_FRAME_BYTES, length queue not full, and the last word fits in the buffer.
- Commit action:
  - wr_commit=wr_ptr+1.
  - Push the length to the queue.
  - good_count++.
- Otherwise the drop action applies:
  - wr_ptr=wr_commit.
  - drop_count++.
  - Byte count and bad flag are cleared.
- Commit or drop takes effect at the clock edge of the tlast handshake. frame_valid rises the cycle after.
- Read side:
  - frame_valid = queue not empty; frame_len = queue head.
  - rd_en while frame_valid: rd_data <= ram[rd_ptr], then rd_ptr++.
  - rd_en is ignored, and rd_data holds, if frame_valid=0 or the frame's ceil(len/4) words are already read.
- frame_pop while frame_valid:
  - Pop the queue.
  - rd_base = rd_base + ceil(frame_len/4); rd_ptr = same value.
  - Freed space is visible to the write side on the next cycle.
  - frame_pop while frame_valid=0 is ignored.
- Simultaneous events:
  - rd_en with frame_pop in the same cycle: pop wins, the read is ignored.
  - Commit and pop in the same cycle: the queue count is unchanged and both pointers update.
- Pointer wrap: pointers wrap modulo 2^(ADDR_WIDTH+1). Frames may straddle the end of the RAM; reads continue from address 0.
- Counters saturate at 16'hFFFF.
- Reset mid-frame: all state is cleared. The next accepted beat is treated as the start of a new frame.

Test Plan:
- 64-byte frame, 16 beats, last tkeep 4'hF, tuser=0 -> frame_valid=1 one cycle after tlast, frame_len=64, good_count=1. 16 rd_en return the words in order, each 1 cycle later.
- 61-byte frame, last tkeep 4'h1 -> frame_len=61. Exactly 16 reads are honoured; a 17th rd_en leaves rd_data unchanged.
- Frame with tuser=1 on tlast -> frame_valid stays 0, drop_count=1. The following 64-byte good frame reads back starting at RAM address 0.
- ADDR_WIDTH=4: 40-byte frame held unread, then 32-byte frame -> second frame dropped, drop_count=1, tready stays 1. After frame_pop the 32-byte frame is resent and accepted, wrapping through address 0.
- Non-last beat with tkeep 4'h3 -> frame dropped. Nine back-to-back 64-byte frames with no reads -> 8 committed, the 9th dropped, good_count=8.
- rst pulsed during beat 5 of a frame -> frame_valid=0, counters=0. The next complete frame commits with the correct length.
